// File: rtl/bcd_stopwatch_ctrl.sv
// Stopwatch controller: 4-digit BCD count (SS.hh, 00.00-59.99), run/pause/clear FSM and display scan.
// Optional macro STOPWATCH_WRAP_EN: terminal tick wraps to 00.00 instead of entering overflow.
module bcd_stopwatch_ctrl #(
    parameter int unsigned TICK_DIV = 500000,
    parameter int unsigned SCAN_DIV = 50000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_stop,
    input  logic        clear,
    output logic [15:0] digits,
    output logic        running,
    output logic        overflow,
    output logic        tick,
    output logic [3:0]  an,
    output logic [3:0]  seg_digit,
    output logic        dp_n
);

    localparam int unsigned PW = $clog2(TICK_DIV);
    localparam int unsigned SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [SW-1:0] SCAN_MAX  = SW'(SCAN_DIV - 1);

`ifdef STOPWATCH_WRAP_EN
    localparam bit WRAP_EN = 1'b1;
`else
    localparam bit WRAP_EN = 1'b0;
`endif

    typedef enum logic [1:0] {StIdle, StRun, StPause, StOvf} state_e;

    state_e        r_state;
    logic [15:0]   r_digits;
    logic [PW-1:0] r_presc;
    logic          r_running;
    logic          r_overflow;
    logic          r_tick;
    logic [SW-1:0] r_scan;
    logic [1:0]    r_sel;
    logic [3:0]    r_an;
    logic [3:0]    r_seg_digit;
    logic          r_dp_n;

    logic [15:0]   w_digits_inc;
    logic          w_presc_done;
    logic          w_terminal;
    logic          w_scan_wrap;
    logic [1:0]    w_sel_d;

    assign w_presc_done = (r_presc == PRESC_MAX);
    assign w_terminal   = (r_digits == 16'h5999);

    // Full carry ripple d0 -> d3 resolved combinationally; 59.99 + 1 yields 00.00.
    always_comb begin
        w_digits_inc = r_digits;
        if (r_digits[3:0] != 4'd9) begin
            w_digits_inc[3:0] = r_digits[3:0] + 4'd1;
        end else begin
            w_digits_inc[3:0] = 4'd0;
            if (r_digits[7:4] != 4'd9) begin
                w_digits_inc[7:4] = r_digits[7:4] + 4'd1;
            end else begin
                w_digits_inc[7:4] = 4'd0;
                if (r_digits[11:8] != 4'd9) begin
                    w_digits_inc[11:8] = r_digits[11:8] + 4'd1;
                end else begin
                    w_digits_inc[11:8] = 4'd0;
                    if (r_digits[15:12] != 4'd5) begin
                        w_digits_inc[15:12] = r_digits[15:12] + 4'd1;
                    end else begin
                        w_digits_inc[15:12] = 4'd0;
                    end
                end
            end
        end
    end

    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= StIdle;
            r_digits   <= '0;
            r_presc    <= '0;
            r_running  <= 1'b0;
            r_overflow <= 1'b0;
            r_tick     <= 1'b0;
        end else begin
            r_tick <= 1'b0;
            if (clear) begin
                r_state    <= StIdle;
                r_digits   <= '0;
                r_presc    <= '0;
                r_running  <= 1'b0;
                r_overflow <= 1'b0;
            end else begin
                unique case (r_state)
                    StIdle: begin
                        r_presc <= '0;
                        if (start_stop) begin
                            r_state   <= StRun;
                            r_running <= 1'b1;
                        end
                    end
                    StRun: begin
                        if (start_stop) begin
                            r_state   <= StPause;
                            r_running <= 1'b0;
                        end
                        if (w_presc_done) begin
                            r_presc <= '0;
                            // Overflow takes priority over a coincident pause request.
                            if (w_terminal && !WRAP_EN) begin
                                r_state    <= StOvf;
                                r_running  <= 1'b0;
                                r_overflow <= 1'b1;
                            end else begin
                                r_digits <= w_digits_inc;
                                r_tick   <= 1'b1;
                            end
                        end else begin
                            r_presc <= r_presc + PW'(1);
                        end
                    end
                    StPause: begin
                        if (start_stop) begin
                            r_state   <= StRun;
                            r_running <= 1'b1;
                        end
                    end
                    StOvf: begin
                        r_presc <= '0;
                    end
                endcase
            end
        end
    end

    assign w_scan_wrap = (r_scan == SCAN_MAX);
    assign w_sel_d     = w_scan_wrap ? r_sel + 2'd1 : r_sel;

    // an/seg_digit/dp_n all derive from the next select so they change on the same edge.
    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            r_scan      <= '0;
            r_sel       <= 2'd0;
            r_an        <= 4'b1110;
            r_seg_digit <= 4'd0;
            r_dp_n      <= 1'b1;
        end else begin
            r_scan      <= w_scan_wrap ? '0 : r_scan + SW'(1);
            r_sel       <= w_sel_d;
            r_an        <= ~(4'b0001 << w_sel_d);
            r_seg_digit <= r_digits[{w_sel_d, 2'b00} +: 4];
            r_dp_n      <= (w_sel_d != 2'd2);
        end
    end

    assign digits    = r_digits;
    assign running   = r_running;
    assign overflow  = WRAP_EN ? 1'b0 : r_overflow;
    assign tick      = r_tick;
    assign an        = r_an;
    assign seg_digit = r_seg_digit;
    assign dp_n      = r_dp_n;

endmodule

// File: tb/tb_bcd_stopwatch_ctrl.sv
// Bench for bcd_stopwatch_ctrl: integer-count reference model compared every cycle, plus literal checks.
// Honours STOPWATCH_WRAP_EN the same way as the design.
module tb_bcd_stopwatch_ctrl;

    localparam int TICK_DIV = 4;
    localparam int SCAN_DIV = 2;
`ifdef STOPWATCH_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_OVF = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_stop;
    logic        clear;
    logic [15:0] digits;
    logic        running, overflow, tick, dp_n;
    logic [3:0]  an, seg_digit;

    int checks = 0;
    int errors = 0;

    bcd_stopwatch_ctrl #(.TICK_DIV(TICK_DIV), .SCAN_DIV(SCAN_DIV)) dut (
        .clk(clk), .reset(reset), .start_stop(start_stop), .clear(clear),
        .digits(digits), .running(running), .overflow(overflow), .tick(tick),
        .an(an), .seg_digit(seg_digit), .dp_n(dp_n)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int c);
        return {4'(c / 1000), 4'((c / 100) % 10), 4'((c / 10) % 10), 4'(c % 10)};
    endfunction

    function automatic logic [3:0] digit_of(input int c, input int s);
        logic [15:0] v;
        v = to_bcd(c);
        return v[4*s +: 4];
    endfunction

    // Reference model: elapsed time as an integer count of hundredths.
    int         m_mode, m_count, m_presc, m_scan, m_sel, m_prev;
    logic       m_tick;
    logic [3:0] m_seg;

    always @(negedge clk or negedge reset) begin
        if (!reset) begin
            m_mode = M_IDLE; m_count = 0; m_presc = 0;
            m_scan = 0; m_sel = 0; m_tick = 1'b0; m_seg = 4'd0;
        end else begin
            m_prev = m_count;
            m_tick = 1'b0;
            if (clear) begin
                m_mode = M_IDLE; m_count = 0; m_presc = 0;
            end else if (m_mode == M_IDLE) begin
                if (start_stop) m_mode = M_RUN;
            end else if (m_mode == M_RUN) begin
                if (m_presc == TICK_DIV - 1) begin
                    m_presc = 0;
                    if (m_count == 5999) begin
                        if (WRAP) begin
                            m_count = 0;
                            m_tick  = 1'b1;
                        end else begin
                            m_mode = M_OVF;
                        end
                    end else begin
                        m_count++;
                        m_tick = 1'b1;
                    end
                end else begin
                    m_presc++;
                end
                if (start_stop && m_mode == M_RUN) m_mode = M_PAUSE;
            end else if (m_mode == M_PAUSE) begin
                if (start_stop) m_mode = M_RUN;
            end
            if (m_scan == SCAN_DIV - 1) begin
                m_scan = 0;
                m_sel  = (m_sel + 1) % 4;
            end else begin
                m_scan++;
            end
            m_seg = digit_of(m_prev, m_sel);
        end
    end

    logic [3:0] an_exp;
    always @(posedge clk) begin
        an_exp = ~(4'b0001 << m_sel);
        chk("digits",    digits,          to_bcd(m_count));
        chk("running",   16'(running),    16'(m_mode == M_RUN));
        chk("overflow",  16'(overflow),   16'(m_mode == M_OVF));
        chk("tick",      16'(tick),       16'(m_tick));
        chk("an",        16'(an),         16'(an_exp));
        chk("seg_digit", 16'(seg_digit),  16'(m_seg));
        chk("dp_n",      16'(dp_n),       16'(m_sel != 2));
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_ss();
        start_stop = 1'b1;
        step(1);
        start_stop = 1'b0;
    endtask

    task automatic pulse_clr();
        clear = 1'b1;
        step(1);
        clear = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    int          ticks;
    logic        found;
    logic [3:0]  prev_an;
    logic [3:0]  exp_an  [8] = '{4'b1110, 4'b1110, 4'b1101, 4'b1101,
                                 4'b1011, 4'b1011, 4'b0111, 4'b0111};
    logic [3:0]  exp_seg [8] = '{4'd4, 4'd4, 4'd3, 4'd3, 4'd2, 4'd2, 4'd1, 4'd1};
    logic        exp_dp  [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    int          r;

    initial begin
        reset = 1'b1; start_stop = 1'b0; clear = 1'b0;
        #1 reset = 1'b0;
        step(3);
        chk("rst_digits", digits, 16'h0000);
        chk("rst_an", 16'(an), 16'h000e);
        chk("rst_dp_n", 16'(dp_n), 16'h0001);
        chk("rst_running", 16'(running), 16'h0000);
        reset = 1'b1;
        step(10);
        chk("idle_nocount", digits, 16'h0000);

        // 40 cycles of run -> 00.10 with ten ticks.
        pulse_ss();
        ticks = 0;
        for (int i = 0; i < 40; i++) begin
            step(1);
            if (tick) ticks++;
        end
        chk("run40_digits", digits, 16'h0010);
        chk("run40_ticks", 16'(ticks), 16'd10);
        chk("run40_running", 16'(running), 16'h0001);

        // Full ripple 09.99 -> 10.00.
        pulse_clr();
        pulse_ss();
        step(999 * TICK_DIV);
        chk("pre_ripple", digits, 16'h0999);
        step(TICK_DIV);
        chk("ripple", digits, 16'h1000);

        // Pause after two prescaler counts, then resume.
        pulse_clr();
        pulse_ss();
        step(1);
        pulse_ss();
        step(100);
        chk("pause_hold", digits, 16'h0000);
        chk("pause_running", 16'(running), 16'h0000);
        pulse_ss();
        step(1);
        chk("resume_1", digits, 16'h0000);
        chk("resume_1_tick", 16'(tick), 16'h0000);
        step(1);
        chk("resume_2", digits, 16'h0001);
        chk("resume_2_tick", 16'(tick), 16'h0001);

        // Count to 12.34 and pause on the tick edge.
        pulse_clr();
        pulse_ss();
        step(1234 * TICK_DIV - 1);
        pulse_ss();
        chk("preload_1234", digits, 16'h1234);
        found = 1'b0;
        prev_an = an;
        for (int i = 0; i < 16 && !found; i++) begin
            step(1);
            if (prev_an == 4'b0111 && an == 4'b1110) found = 1'b1;
            prev_an = an;
        end
        chk("scan_align", 16'(found), 16'h0001);
        for (int i = 0; i < 8; i++) begin
            chk("scan_an", 16'(an), 16'(exp_an[i]));
            chk("scan_seg", 16'(seg_digit), 16'(exp_seg[i]));
            chk("scan_dp", 16'(dp_n), 16'(exp_dp[i]));
            step(1);
        end

        // Asynchronous reset in the middle of a run.
        pulse_ss();
        step(2);
        reset = 1'b0;
        #1;
        chk("async_digits", digits, 16'h0000);
        chk("async_an", 16'(an), 16'h000e);
        chk("async_running", 16'(running), 16'h0000);
        step(2);
        reset = 1'b1;
        step(10);
        chk("post_rst_idle", digits, 16'h0000);

        // clear and start_stop together: clear wins.
        pulse_ss();
        step(5);
        clear = 1'b1; start_stop = 1'b1;
        step(1);
        clear = 1'b0; start_stop = 1'b0;
        chk("clr_ss_running", 16'(running), 16'h0000);
        chk("clr_ss_digits", digits, 16'h0000);
        step(10);
        chk("clr_ss_idle", digits, 16'h0000);

        // Terminal tick at 59.99.
        pulse_clr();
        pulse_ss();
        step(5999 * TICK_DIV);
        chk("pre_term", digits, 16'h5999);
        step(TICK_DIV);
`ifdef STOPWATCH_WRAP_EN
        chk("wrap_digits", digits, 16'h0000);
        chk("wrap_running", 16'(running), 16'h0001);
        chk("wrap_ovf", 16'(overflow), 16'h0000);
`else
        chk("ovf_digits", digits, 16'h5999);
        chk("ovf_flag", 16'(overflow), 16'h0001);
        chk("ovf_running", 16'(running), 16'h0000);
        pulse_ss();
        step(20);
        chk("ovf_ss_digits", digits, 16'h5999);
        chk("ovf_ss_flag", 16'(overflow), 16'h0001);
`endif
        pulse_clr();
        chk("term_clr_digits", digits, 16'h0000);
        chk("term_clr_running", 16'(running), 16'h0000);
        chk("term_clr_ovf", 16'(overflow), 16'h0000);

        // Random command traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            r = int'($urandom_range(0, 199));
            start_stop = (r < 20) || (r >= 30 && r < 33);
            clear      = (r >= 20 && r < 33);
            reset      = (r != 199);
            step(1);
        end
        start_stop = 1'b0; clear = 1'b0; reset = 1'b1;
        step(5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
